// File: rtl/blackbox_monitor.sv
// Debounces the sampled blackbox output l, strobes its rising edges and keeps a
// saturating rise count with a sticky threshold alarm. All outputs are registered.
module blackbox_monitor #(
  parameter int STABLE = 3,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             l_in,
  input  logic             sample_en,
  input  logic             clear,
  output logic             l_stable,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] rise_count,
  output logic             alarm
);

  localparam int RUN_W = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
  localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             stable_q, stable_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             alarm_q, alarm_d;
  logic             differs, flip, rise;

  assign differs = sample_en && (l_in != stable_q);
  assign flip    = differs && (run_q == RUN_LAST);
  assign rise    = flip && !stable_q;

  always_comb begin
    stable_d = stable_q;
    run_d    = run_q;
    count_d  = count_q;
    alarm_d  = alarm_q;
    // The strobe lasts one cycle even if the next edge is a sampling stall.
    pulse_d  = rise;

    if (flip) begin
      stable_d = ~stable_q;
    end

    if (clear) begin
      run_d   = '0;
      count_d = '0;
      alarm_d = 1'b0;
    end else begin
      if (sample_en) begin
        if (!differs || flip) begin
          run_d = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      if (rise && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_W'(1);
      end
      if (rise && (count_d == CNT_THRESH)) begin
        alarm_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      run_q    <= '0;
      pulse_q  <= 1'b0;
      count_q  <= '0;
      alarm_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      run_q    <= run_d;
      pulse_q  <= pulse_d;
      count_q  <= count_d;
      alarm_q  <= alarm_d;
    end
  end

  assign l_stable   = stable_q;
  assign rise_pulse = pulse_q;
  assign rise_count = count_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_blackbox_monitor.sv
// Directed bench: default instance (STABLE=3, CNT_W=8, THRESH=4) and a corner
// instance (STABLE=1, CNT_W=3, THRESH=1) for saturation and single-sample flips.
module tb_blackbox_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b0, l0 = 1'b0, en0 = 1'b0, clr0 = 1'b0;
  logic       stab0, pulse0, alarm0;
  logic [7:0] cnt0;

  logic       rst1 = 1'b0, l1 = 1'b0, en1 = 1'b0, clr1 = 1'b0;
  logic       stab1, pulse1, alarm1;
  logic [2:0] cnt1;

  logic j = 1'b0, v = 1'b0, f = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  blackbox_monitor #(.STABLE(3), .CNT_W(8), .THRESH(4)) dut0 (
    .clk(clk), .reset_n(rst0), .l_in(l0), .sample_en(en0), .clear(clr0),
    .l_stable(stab0), .rise_pulse(pulse0), .rise_count(cnt0), .alarm(alarm0)
  );

  blackbox_monitor #(.STABLE(1), .CNT_W(3), .THRESH(1)) dut1 (
    .clk(clk), .reset_n(rst1), .l_in(l1), .sample_en(en1), .clear(clr1),
    .l_stable(stab1), .rise_pulse(pulse1), .rise_count(cnt1), .alarm(alarm1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input int s, input int p, input int c, input int a);
    chk({tag, ".l_stable"}, int'(stab0), s);
    chk({tag, ".rise_pulse"}, int'(pulse0), p);
    chk({tag, ".rise_count"}, int'(cnt0), c);
    chk({tag, ".alarm"}, int'(alarm0), a);
  endtask

  task automatic chk1(input string tag, input int s, input int p, input int c, input int a);
    chk({tag, ".l_stable"}, int'(stab1), s);
    chk({tag, ".rise_pulse"}, int'(pulse1), p);
    chk({tag, ".rise_count"}, int'(cnt1), c);
    chk({tag, ".alarm"}, int'(alarm1), a);
  endtask

  initial begin
    int exp_cnt;
    #2;
    // Reset held for two edges with l=1 sampled.
    rst0 = 0; l0 = 1; en0 = 1; clr0 = 0;
    tick(); tick();
    chk0("rst", 0, 0, 0, 0);
    rst0 = 1;
    tick(); chk0("rel1", 0, 0, 0, 0);
    tick(); chk0("rel2", 0, 0, 0, 0);
    tick(); chk0("rel3", 1, 1, 1, 0);
    tick(); chk0("rel4", 1, 0, 1, 0);

    // Fall back to 0 (no pulse on a falling flip).
    l0 = 0;
    tick(); tick(); chk0("fall_pre", 1, 0, 1, 0);
    tick(); chk0("fall", 0, 0, 1, 0);

    // Two-sample glitch is filtered.
    l0 = 1; tick(); tick();
    l0 = 0; tick(); chk0("glitch_a", 0, 0, 1, 0);
    tick(); chk0("glitch_b", 0, 0, 1, 0);
    l0 = 1; tick(); tick(); chk0("clean_pre", 0, 0, 1, 0);
    tick(); chk0("clean", 1, 1, 2, 0);
    tick(); chk0("clean_post", 1, 0, 2, 0);

    // Sampling gaps hold the run.
    l0 = 0; tick(); tick(); tick(); chk0("gap_base", 0, 0, 2, 0);
    l0 = 1;
    en0 = 1; tick();
    en0 = 0; tick();
    en0 = 0; tick();
    en0 = 1; tick();
    en0 = 0; tick(); chk0("gap_e5", 0, 0, 2, 0);
    en0 = 1; tick(); chk0("gap_e6", 1, 1, 3, 0);
    en0 = 0; tick(); chk0("gap_stall", 1, 0, 3, 0);
    en0 = 1; l0 = 0; tick(); tick(); tick(); chk0("gap_fall", 0, 0, 3, 0);

    // Fourth rise raises the alarm together with the count.
    l0 = 1; tick(); tick(); chk0("al4_pre", 0, 0, 3, 0);
    tick(); chk0("al4", 1, 1, 4, 1);
    l0 = 0; tick(); tick(); tick();
    l0 = 1; tick(); tick(); tick(); chk0("al5", 1, 1, 5, 1);
    clr0 = 1; tick(); chk0("clr", 1, 0, 0, 0);
    clr0 = 0; tick(); chk0("clr_post", 1, 0, 0, 0);

    // Reset mid-debounce.
    l0 = 0; tick(); tick();
    rst0 = 0; l0 = 1; tick(); chk0("rst_mid", 0, 0, 0, 0);
    rst0 = 1; l0 = 0; tick(); tick(); tick(); chk0("rst_mid_post", 0, 0, 0, 0);

    // Blackbox-driven input: l = f & (~v | j).
    j = 0; v = 1; f = 1; l0 = f & (~v | j);
    tick(); tick(); tick(); chk0("e2e_low", 0, 0, 0, 0);
    j = 1; v = 1; f = 1; l0 = f & (~v | j);
    tick(); tick(); chk0("e2e_pre", 0, 0, 0, 0);
    tick(); chk0("e2e_rise", 1, 1, 1, 0);
    tick(); chk0("e2e_post", 1, 0, 1, 0);

    // Corner instance: STABLE=1, CNT_W=3, THRESH=1.
    rst1 = 0; l1 = 1; en1 = 1; clr1 = 0;
    tick(); chk1("c_rst", 0, 0, 0, 0);
    rst1 = 1; l1 = 1;
    tick(); chk1("c_rise1", 1, 1, 1, 1);
    for (int k = 2; k <= 9; k++) begin
      l1 = 0; tick(); chk1("c_fall", 0, 0, (k - 1 > 7) ? 7 : k - 1, 1);
      l1 = 1; tick();
      exp_cnt = (k > 7) ? 7 : k;
      chk1("c_rise", 1, 1, exp_cnt, 1);
    end
    l1 = 0; tick();
    l1 = 1; clr1 = 1; tick(); chk1("c_clr_rise", 1, 1, 0, 0);
    clr1 = 0; tick(); chk1("c_clr_post", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blackbox_monitor.md
# blackbox_monitor

Downstream consumer of the `blackbox` output `l` (`l = f & (~v | j)`). It debounces the sampled `l` and detects its rising edges. It also keeps a saturating count of those rising edges and raises a sticky alarm when the count reaches a programmable threshold. It turns the purely combinational `blackbox` result into a stable, event-level signal for later lab stages.

## Interface
- `STABLE`, default 3: number of consecutive enabled samples that must differ from `l_stable` before it flips. Legal range is ≥ 1.
- `CNT_W`, default 8: width of the rise counter.
- `THRESH`, default 4: rise count at which `alarm` sets. Legal range is 1 … 2^CNT_W−1.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `l_in`  in  1  `l` output of `blackbox`.
- `sample_en`  in  1  when 1, `l_in` is sampled this cycle; when 0, all state holds.
- `clear`  in  1  synchronous clear of counter, alarm and debounce run length.
- `l_stable`  out  1  debounced `l`.
- `rise_pulse`  out  1  one-cycle strobe on a 0→1 transition of `l_stable`.
- `rise_count`  out  CNT_W  saturating count of `l_stable` rising edges.
- `alarm`  out  1  sticky; set when `rise_count` reaches THRESH.

## Operation
- **Reset.** `reset_n`=0 at an edge forces `l_stable`=0, internal run=0, `rise_pulse`=0, `rise_count`=0, `alarm`=0. Reset overrides every other input, including mid-debounce.
- **Run counter.** Internal `run` has width clog2(STABLE+1). On an edge with `sample_en`=1:
  - If `l_in` == `l_stable`: run←0.
  - If `l_in` != `l_stable` and run < STABLE−1: run←run+1.
  - If `l_in` != `l_stable` and run == STABLE−1: `l_stable`←~`l_stable` and run←0. This is the flip.
- **Stalls.** Edges with `sample_en`=0 change nothing. Run is held, not reset, so a gap in sampling does not break a run.
- **Rising edge.** A flip 0→1 is a rising edge. `rise_pulse` is a registered strobe: it is 1 exactly in the cycle following the flip edge and 0 otherwise. A 1→0 flip gives no pulse.
- **Counting.** On a rising edge, `rise_count`←`rise_count`+1, saturating at 2^CNT_W−1 with no wrap.
- **Alarm.** `alarm` sets on the same edge at which `rise_count` becomes THRESH. It stays 1 until `clear` or reset, including while the count saturates.
- **Clear.** `clear`=1 at an edge (with `reset_n`=1) forces `rise_count`=0, `alarm`=0, run=0. It does not alter `l_stable`.
- **Clear and rising edge on the same edge.** `clear` wins for the counter and alarm: `rise_count`=0 and `alarm`=0. The flip still occurs, `l_stable`←1, and `rise_pulse` still asserts.
- **THRESH=1.** `alarm` sets on the first counted rise.
- **STABLE=1.** Any single differing sample flips `l_stable`.

## Timing
- **Debounce latency.** With `sample_en` held at 1, `l_in` changing before edge k and held makes `l_stable` change after edge k+STABLE−1. This is STABLE cycles.
- **Output timing.** `rise_pulse`, the new `rise_count` and `alarm` all become visible in the same cycle as the new `l_stable`. All are registered; there are no combinational input→output paths.
- **Pulse width.** `rise_pulse` is never high for two consecutive cycles. The minimum spacing between pulses is 2·STABLE enabled samples.
- **Filtering.** A pulse on `l_in` shorter than STABLE enabled samples is filtered completely.
- **Reset latency.** Outputs read reset values in the cycle after the first edge with `reset_n`=0.

## Test plan
- **Reset.** Hold `reset_n`=0 for 2 edges with `l_in`=1 and `sample_en`=1 → all outputs 0. Release reset, keep `l_in`=1 → `l_stable`=1 and `rise_pulse`=1 after the 3rd edge, `rise_count`=1, then `rise_pulse`=0 next cycle.
- **Glitch filter.** STABLE=3. `l_in` 1 for 2 samples then 0 → `l_stable` stays 0, `rise_count` stays 0. Then 1 for 3 samples → exactly one pulse, count=1.
- **Sampling gaps.** Drive `l_in`=1 with `sample_en` pattern 1,0,0,1,0,1 → the flip occurs on the 3rd enabled edge (6th edge overall). Drop `l_in`=0 for 3 samples → `l_stable`=0 with no pulse.
- **Alarm.** THRESH=4. Drive 4 clean rises → `alarm` rises in the same cycle `rise_count` reads 4. A 5th rise → count=5, `alarm` still 1. Pulse `clear` → count=0, `alarm`=0, `l_stable` unchanged.
- **Saturation.** CNT_W=3. Drive 9 rises → `rise_count` sticks at 7, no wrap. `clear` coincident with a rising flip → count=0, `rise_pulse`=1, `l_stable`=1.
- **End-to-end.** Drive `blackbox` with (j,v,f)=(0,1,1), hold for 3 samples → `l_in`=0, no change. Switch to (1,1,1) or (0,0,1) held for 3 samples → `l_stable`=1, `rise_pulse` asserted once.
